bram_dual_be: RTL and testbench
===============================

// Module: bram_dual_be
// PURPOSE
//   Simple dual-port inferred block RAM (1 write port, 1 read port, one clock) with byte-write enables,
//   read enable, byte-merged write-through forwarding and an optional output register stage.
//   Serves as the register-file, cache-data and scratchpad backing store for the core.
//   Read data is flagged with a valid strobe.
// PARAMETERS
//   memSize_p  6   address width; depth = 2**memSize_p words
//   XLEN       32  word width in bits; must be a multiple of 8; NB = XLEN/8 byte lanes
//   OUT_REG_p  0   0: read latency 1 cycle; 1: extra output register, read latency 2 cycles
// PORTS
//   clk_i         in   1          clock; all logic on rising edge
//   rst_ni        in   1          synchronous active-low reset
//   write_i       in   1          write strobe
//   be_i          in   XLEN/8     byte-write enables; bit k covers data_i[8k+7:8k]
//   waddr_i       in   memSize_p  write address
//   data_i        in   XLEN       write data
//   read_i        in   1          read enable
//   raddr_i       in   memSize_p  read address
//   inject_err_i  in   1          test-only: corrupt stored parity of byte 0 on this write
//   data_o        out  XLEN       read data
//   rvalid_o      out  1          single-cycle pulse: data_o holds result of a read
//   parity_err_o  out  1          parity mismatch on the read presented with rvalid_o
// BEHAVIOUR
// - Memory array has no reset; contents are undefined until written and survive rst_ni.
// - Reset (rst_ni=0 at a clock edge):
//   - rvalid_o=0, parity_err_o=0, data_o=0; write-through flag and mask registers cleared.
//   - Writes and reads issued in that cycle are ignored.
// - Write: on write_i=1, for every k with be_i[k]=1, mem[waddr_i] byte k <= data_i byte k.
//   - Disabled bytes are unchanged. be_i=0 with write_i=1 is a no-op.
// - Read, stage 1 (edge N, read_i=1):
//   - capture mem[raddr_i] old contents; capture data_i.
//   - capture fwd_mask = be_i when (write_i && waddr_i==raddr_i), else 0.
// - Merged word = per byte: fwd_mask[k] ? captured data_i byte : captured old byte.
//   A read colliding with a write therefore returns new data on written bytes and old data elsewhere.
// - read_i=0: stage-1 registers hold; data_o holds its last value; rvalid_o=0.
// - OUT_REG_p=0: data_o = merged word, combinationally after stage 1.
//   - rvalid_o=1 in cycle N+1 only.
// - OUT_REG_p=1: at edge N+1, if stage-1 valid, output register <= merged word.
//   - data_o/rvalid_o presented in cycle N+2. Back-to-back reads sustain 1 word/cycle.
// - Reads to the same address on consecutive cycles after a write return the written data.
//   No hazard beyond the same-cycle collision handled above.
// - Reset asserted mid-pipeline drops in-flight reads; no rvalid_o is produced for them.
// - Address wrap: none; addresses are exactly memSize_p bits.
// CONFIGURATION
//   BRAM_PARITY_EN defined:
//   - Each word stores NB even-parity bits; parity is computed per written byte and stored with
//     the byte under its be_i bit.
//   - inject_err_i=1 on a write with be_i[0]=1 stores inverted parity for byte 0.
//   - On read, parity is recomputed per byte on stored data. Forwarded bytes are never flagged.
//   - parity_err_o = OR of mismatches, aligned with rvalid_o (same latency as data_o).
//   BRAM_PARITY_EN undefined:
//   - No parity storage; parity_err_o tied 0; inject_err_i ignored.
//   - Array is exactly XLEN bits wide.
// TESTING
// 1. Reset:
//    rst_ni=0 two cycles with read_i=1
//    -> rvalid_o=0, data_o=0, parity_err_o=0.
// 2. Byte write:
//    write addr 5 data 0xAABBCCDD be=1111; then write addr 5 data 0x11223344 be=0101; then read 5
//    -> data_o=0xAA22CC44, rvalid_o pulse at latency 1 (OUT_REG_p=0) / 2 (OUT_REG_p=1).
// 3. Collision:
//    mem[9]=0x01020304; same cycle write 9 data 0xF0F0F0F0 be=1100 and read 9
//    -> data_o=0xF0F00304; next read 9 -> 0xF0F00304.
// 4. Read-enable hold:
//    read addr 3 (0xDEADBEEF), then read_i=0 for 3 cycles while writing addr 3
//    -> data_o stays 0xDEADBEEF, rvalid_o=0 in hold cycles.
// 5. Streaming with reset:
//    reads of addr 0..7 back-to-back -> 8 consecutive rvalid_o pulses, in order.
//    Same stream with rst_ni=0 at the 4th edge -> no rvalid_o after reset.
// 6. Parity (BRAM_PARITY_EN):
//    write addr 2 0x12345678 be=1111 inject_err_i=1; read 2
//    -> parity_err_o=1 with rvalid_o, data_o=0x12345678.
//    Rewrite without inject; read -> parity_err_o=0.
//    Without macro -> parity_err_o=0 always.

Source files
------------

// File: rtl/bram_dual_be.sv
// Simple dual-port block RAM with byte-write enables, byte-merged write-through and optional output register.
// Optional feature: define BRAM_PARITY_EN to store per-byte even parity and flag mismatches on read.
module bram_dual_be #(
  parameter int unsigned memSize_p = 6,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OUT_REG_p = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 write_i,
  input  logic [XLEN/8-1:0]    be_i,
  input  logic [memSize_p-1:0] waddr_i,
  input  logic [XLEN-1:0]      data_i,
  input  logic                 read_i,
  input  logic [memSize_p-1:0] raddr_i,
  input  logic                 inject_err_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 rvalid_o,
  output logic                 parity_err_o
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned DEPTH = 1 << memSize_p;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_q;
  logic [XLEN-1:0] wd_q;
  logic [XLEN-1:0] merged_c;
  logic [NB-1:0]   fwd_q;
  logic [NB-1:0]   perr_byte_c;
  logic            s1_valid_q;
  logic            perr_c;
  logic            unused_inject;

  // Data array: no reset, only enabled bytes are written
  always_ff @(posedge clk_i) begin
    if (rst_ni && write_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) mem[waddr_i][8*k +: 8] <= data_i[8*k +: 8];
      end
    end
  end

  // Read stage 1: old word, concurrent write data and per-byte forward mask
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      fwd_q      <= '0;
    end else begin
      s1_valid_q <= read_i;
      if (read_i) begin
        rd_q  <= mem[raddr_i];
        wd_q  <= data_i;
        fwd_q <= (write_i && (waddr_i == raddr_i)) ? be_i : '0;
      end
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_merge
    assign merged_c[8*k +: 8] = fwd_q[k] ? wd_q[8*k +: 8] : rd_q[8*k +: 8];
  end

`ifdef BRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_q;
  logic [NB-1:0] wpar_c;

  for (genvar k = 0; k < NB; k++) begin : g_par
    if (k == 0) begin : g_inj
      assign wpar_c[k] = (^data_i[8*k +: 8]) ^ inject_err_i;
    end else begin : g_norm
      assign wpar_c[k] = ^data_i[8*k +: 8];
    end
    // Forwarded bytes bypass the array, so they are never checked
    assign perr_byte_c[k] = ((^rd_q[8*k +: 8]) != par_q[k]) && !fwd_q[k];
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && write_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) par_mem[waddr_i][k] <= wpar_c[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      par_q <= '0;
    end else if (read_i) begin
      par_q <= par_mem[raddr_i];
    end
  end
`else
  assign perr_byte_c = '0;
`endif

  assign perr_c        = s1_valid_q && (|perr_byte_c);
  assign unused_inject = inject_err_i;

  if (OUT_REG_p != 0) begin : g_out_reg
    logic [XLEN-1:0] data_q;
    logic            rvalid_q;
    logic            perr_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        data_q   <= '0;
        rvalid_q <= 1'b0;
        perr_q   <= 1'b0;
      end else begin
        rvalid_q <= s1_valid_q;
        perr_q   <= perr_c;
        if (s1_valid_q) data_q <= merged_c;
      end
    end

    assign data_o       = data_q;
    assign rvalid_o     = rvalid_q;
    assign parity_err_o = perr_q;
  end else begin : g_out_comb
    assign data_o       = merged_c;
    assign rvalid_o     = s1_valid_q;
    assign parity_err_o = perr_c;
  end

endmodule

// File: tb/tb_bram_dual_be.sv
// Self-checking bench for bram_dual_be: vector table plus directed hold/stream/reset sequences.
// Expected read results are queued at issue time and checked when rvalid_o appears.
module tb_bram_dual_be;

  localparam int unsigned AW      = 6;
  localparam int unsigned XL      = 32;
  localparam int unsigned NB      = XL / 8;
  localparam int unsigned OUT_REG = 0;
  localparam int          LAT     = int'(OUT_REG) + 1;
`ifdef BRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk_i;
  logic          rst_ni;
  logic          write_i;
  logic [NB-1:0] be_i;
  logic [AW-1:0] waddr_i;
  logic [XL-1:0] data_i;
  logic          read_i;
  logic [AW-1:0] raddr_i;
  logic          inject_err_i;
  logic [XL-1:0] data_o;
  logic          rvalid_o;
  logic          parity_err_o;

  bram_dual_be #(.memSize_p(AW), .XLEN(XL), .OUT_REG_p(OUT_REG)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .write_i(write_i), .be_i(be_i),
    .waddr_i(waddr_i), .data_i(data_i), .read_i(read_i), .raddr_i(raddr_i),
    .inject_err_i(inject_err_i), .data_o(data_o), .rvalid_o(rvalid_o),
    .parity_err_o(parity_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XL-1:0] data;
    logic          perr;
    int            due;
  } exp_t;

  typedef struct {
    logic          rst_n;
    logic          w;
    logic [NB-1:0] be;
    logic [AW-1:0] wa;
    logic [XL-1:0] d;
    logic          r;
    logic [AW-1:0] ra;
    logic          inj;
    logic [XL-1:0] xd;
    logic          xp;
  } vec_t;

  exp_t          sb[$];
  logic [XL-1:0] model [64];
  bit            bad0  [64];
  int            cyc    = 0;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic vec_t mk(logic rst_n, logic w, logic [NB-1:0] be, logic [AW-1:0] wa,
                              logic [XL-1:0] d, logic r, logic [AW-1:0] ra, logic inj,
                              logic [XL-1:0] xd, logic xp);
    vec_t v;
    v.rst_n = rst_n; v.w = w; v.be = be; v.wa = wa; v.d = d;
    v.r = r; v.ra = ra; v.inj = inj; v.xd = xd; v.xp = xp;
    return v;
  endfunction

  // Drive one cycle, maintain the model/scoreboard, then check outputs at the falling edge
  task automatic step(input vec_t v, input bit use_tbl);
    exp_t e;
    exp_t keep[$];
    rst_ni = v.rst_n; write_i = v.w; be_i = v.be; waddr_i = v.wa; data_i = v.d;
    read_i = v.r; raddr_i = v.ra; inject_err_i = v.inj;
    if (!v.rst_n) begin
      foreach (sb[i]) if (sb[i].due < cyc + 1) keep.push_back(sb[i]);
      sb = keep;
    end else begin
      if (v.r) begin
        for (int k = 0; k < NB; k++)
          e.data[8*k +: 8] = (v.w && v.wa == v.ra && v.be[k]) ? v.d[8*k +: 8]
                                                              : model[v.ra][8*k +: 8];
        e.perr = PAR && bad0[v.ra] && !(v.w && v.wa == v.ra && v.be[0]);
        if (use_tbl) begin
          e.data = v.xd;
          e.perr = v.xp;
        end
        e.due = cyc + LAT;
        sb.push_back(e);
      end
      if (v.w) begin
        for (int k = 0; k < NB; k++)
          if (v.be[k]) model[v.wa][8*k +: 8] = v.d[8*k +: 8];
        if (v.be[0]) bad0[v.wa] = v.inj;
      end
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    if (rvalid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {31'b0, rvalid_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_latency", cyc, e.due);
        chk("rdata", data_o, e.data);
        chk("parity_err", {31'b0, parity_err_o}, {31'b0, e.perr});
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("rvalid_missing", {31'b0, rvalid_o}, 32'd1);
      void'(sb.pop_front());
    end
  endtask

  vec_t tbl[16];
  vec_t idle;

  initial begin
    idle = mk(1, 0, '0, '0, '0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 64; i++) begin
      model[i] = '0;
      bad0[i]  = 1'b0;
    end

    //         rst w  be     wa  data          r  ra inj exp_data      exp_perr
    tbl[0]  = mk(1, 1, 4'hF, 5,  32'hAABBCCDD, 0, 0, 0, '0,           0);
    tbl[1]  = mk(1, 1, 4'h5, 5,  32'h11223344, 0, 0, 0, '0,           0);
    tbl[2]  = mk(1, 0, 4'h0, 0,  '0,           1, 5, 0, 32'hAA22CC44, 0);
    tbl[3]  = mk(1, 1, 4'hF, 9,  32'h01020304, 0, 0, 0, '0,           0);
    tbl[4]  = mk(1, 1, 4'hC, 9,  32'hF0F0F0F0, 1, 9, 0, 32'hF0F00304, 0);
    tbl[5]  = mk(1, 0, 4'h0, 0,  '0,           1, 9, 0, 32'hF0F00304, 0);
    tbl[6]  = mk(1, 1, 4'hF, 3,  32'hDEADBEEF, 0, 0, 0, '0,           0);
    tbl[7]  = mk(1, 1, 4'hF, 2,  32'h12345678, 0, 0, 1, '0,           0);
    tbl[8]  = mk(1, 0, 4'h0, 0,  '0,           1, 2, 0, 32'h12345678, PAR);
    tbl[9]  = mk(1, 1, 4'hF, 2,  32'h12345678, 0, 0, 0, '0,           0);
    tbl[10] = mk(1, 0, 4'h0, 0,  '0,           1, 2, 0, 32'h12345678, 0);
    tbl[11] = mk(1, 1, 4'h1, 2,  32'h000000AB, 1, 2, 1, 32'h123456AB, 0);
    tbl[12] = mk(1, 0, 4'h0, 0,  '0,           1, 2, 0, 32'h123456AB, PAR);
    tbl[13] = mk(1, 1, 4'h0, 5,  32'hFFFFFFFF, 0, 0, 0, '0,           0);
    tbl[14] = mk(1, 0, 4'h0, 0,  '0,           1, 5, 0, 32'hAA22CC44, 0);
    tbl[15] = mk(1, 1, 4'hF, 7,  32'hCAFEF00D, 1, 3, 0, 32'hDEADBEEF, 0);

    // Reset with read requested: nothing may come out
    for (int i = 0; i < 2; i++) begin
      step(mk(0, 0, '0, '0, '0, 1, 5, 0, '0, 0), 0);
      chk("reset_rvalid", {31'b0, rvalid_o}, 32'd0);
      chk("reset_data", data_o, 32'd0);
      chk("reset_perr", {31'b0, parity_err_o}, 32'd0);
    end

    foreach (tbl[i]) step(tbl[i], 1);
    for (int i = 0; i < LAT + 1; i++) step(idle, 0);

    // Read-enable hold while the address is overwritten
    step(mk(1, 0, '0, '0, '0, 1, 3, 0, '0, 0), 0);
    for (int i = 0; i < LAT - 1; i++) step(idle, 0);
    chk("hold_first", data_o, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 1, 4'hF, 3, 32'h55555555, 0, 0, 0, '0, 0), 0);
      chk("hold_data", data_o, 32'hDEADBEEF);
      chk("hold_rvalid", {31'b0, rvalid_o}, 32'd0);
    end
    step(mk(1, 0, '0, '0, '0, 1, 3, 0, '0, 0), 0);
    for (int i = 0; i < LAT + 1; i++) step(idle, 0);

    // Streaming reads of 0..7
    for (int i = 0; i < 8; i++)
      step(mk(1, 1, 4'hF, AW'(i), 32'hA5000000 + 32'(i * 17), 0, 0, 0, '0, 0), 0);
    for (int i = 0; i < 8; i++)
      step(mk(1, 0, '0, '0, '0, 1, AW'(i), 0, '0, 0), 0);
    for (int i = 0; i < LAT + 1; i++) step(idle, 0);

    // Same stream, reset on the 4th edge drops whatever is still in flight
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, '0, '0, '0, 1, AW'(i), 0, '0, 0), 0);
    step(mk(0, 0, '0, '0, '0, 1, 3, 0, '0, 0), 0);
    chk("midreset_data", data_o, 32'd0);
    chk("midreset_rvalid", {31'b0, rvalid_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(idle, 0);
      chk("post_reset_rvalid", {31'b0, rvalid_o}, 32'd0);
    end

    // Contents survive reset
    step(mk(1, 0, '0, '0, '0, 1, 6, 0, '0, 0), 0);
    step(mk(1, 0, '0, '0, '0, 1, 9, 0, '0, 0), 0);
    for (int i = 0; i < LAT + 1; i++) step(idle, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
